// File: rtl/div_issue_ctrl_pkg.sv
// Shared types and constants for the divider issue controller.
// Op bit indices match the one-hot EXE encoding {mod_wu, div_wu, mod_w, div_w}.
package div_issue_ctrl_pkg;

  localparam int DW_DEFAULT = 32;

  localparam int OP_DIV_W  = 0;
  localparam int OP_MOD_W  = 1;
  localparam int OP_DIV_WU = 2;
  localparam int OP_MOD_WU = 3;

  typedef enum logic [4:0] {
    ST_IDLE  = 5'b00001,
    ST_ISSUE = 5'b00010,
    ST_WAIT  = 5'b00100,
    ST_DONE  = 5'b01000,
    ST_DRAIN = 5'b10000
  } state_t;

  // Multi-hot ops resolve to the lowest set bit.
  function automatic logic [3:0] op_lowest(input logic [3:0] op);
    return op & (~op + 4'd1);
  endfunction

endpackage

// File: rtl/div_issue_ctrl_if.sv
// EXE-side and divider-IP-side signals of the issue controller.
// Handshake: a transfer happens on a clk edge where tvalid & tready are both high; once tvalid is raised the tdata stays stable until that edge. dout_tvalid is a one-cycle pulse with no backpressure.
interface div_issue_ctrl_if
  import div_issue_ctrl_pkg::*;
#(
  parameter int DW = DW_DEFAULT
);
  logic          ex_valid;
  logic [3:0]    ex_div_op;
  logic [DW-1:0] ex_src1;
  logic [DW-1:0] ex_src2;
  logic          ex_flush;
  logic          ms_allowin;
  logic          div_stall;
  logic [DW-1:0] div_result;
  logic          div_result_valid;

  logic            s_dvs_tvalid, s_dvd_tvalid, s_dvs_tready, s_dvd_tready;
  logic [DW-1:0]   s_dvs_tdata, s_dvd_tdata;
  logic            s_dout_tvalid;
  logic [2*DW-1:0] s_dout_tdata;

  logic            u_dvs_tvalid, u_dvd_tvalid, u_dvs_tready, u_dvd_tready;
  logic [DW-1:0]   u_dvs_tdata, u_dvd_tdata;
  logic            u_dout_tvalid;
  logic [2*DW-1:0] u_dout_tdata;

  modport master (
    input  ex_valid, ex_div_op, ex_src1, ex_src2, ex_flush, ms_allowin,
    output div_stall, div_result, div_result_valid,
    output s_dvs_tvalid, s_dvd_tvalid, s_dvs_tdata, s_dvd_tdata,
    input  s_dvs_tready, s_dvd_tready, s_dout_tvalid, s_dout_tdata,
    output u_dvs_tvalid, u_dvd_tvalid, u_dvs_tdata, u_dvd_tdata,
    input  u_dvs_tready, u_dvd_tready, u_dout_tvalid, u_dout_tdata
  );

  modport slave (
    output ex_valid, ex_div_op, ex_src1, ex_src2, ex_flush, ms_allowin,
    input  div_stall, div_result, div_result_valid,
    input  s_dvs_tvalid, s_dvd_tvalid, s_dvs_tdata, s_dvd_tdata,
    output s_dvs_tready, s_dvd_tready, s_dout_tvalid, s_dout_tdata,
    input  u_dvs_tvalid, u_dvd_tvalid, u_dvs_tdata, u_dvd_tdata,
    output u_dvs_tready, u_dvd_tready, u_dout_tvalid, u_dout_tdata
  );

endinterface

// File: rtl/div_issue_ctrl_chan_issue.sv
// Issues one operand pair on the divisor/dividend channels of a divider IP.
// An abort is honoured only while neither channel has been (or is being) accepted.
module div_chan_issue (
  input  logic clk,
  input  logic rst,
  input  logic i_start,
  input  logic i_abort_ok,
  input  logic i_dvs_tready,
  input  logic i_dvd_tready,
  output logic o_dvs_tvalid,
  output logic o_dvd_tvalid,
  output logic o_issued,
  output logic o_any_acc
);

  logic r_busy;
  logic r_dvs_tvalid, r_dvd_tvalid;
  logic r_dvs_acc, r_dvd_acc;

  logic w_dvs_hs, w_dvd_hs;
  logic w_dvs_done, w_dvd_done;

  assign w_dvs_hs   = r_dvs_tvalid & i_dvs_tready;
  assign w_dvd_hs   = r_dvd_tvalid & i_dvd_tready;
  assign w_dvs_done = r_dvs_acc | w_dvs_hs;
  assign w_dvd_done = r_dvd_acc | w_dvd_hs;

  assign o_dvs_tvalid = r_dvs_tvalid;
  assign o_dvd_tvalid = r_dvd_tvalid;
  assign o_issued     = r_busy & w_dvs_done & w_dvd_done;
  assign o_any_acc    = r_busy & (w_dvs_done | w_dvd_done);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy       <= 1'b0;
      r_dvs_tvalid <= 1'b0;
      r_dvd_tvalid <= 1'b0;
      r_dvs_acc    <= 1'b0;
      r_dvd_acc    <= 1'b0;
    end else if (i_start) begin
      r_busy       <= 1'b1;
      r_dvs_tvalid <= 1'b1;
      r_dvd_tvalid <= 1'b1;
      r_dvs_acc    <= 1'b0;
      r_dvd_acc    <= 1'b0;
    end else if (r_busy) begin
      if (o_issued || (i_abort_ok && !o_any_acc)) begin
        r_busy       <= 1'b0;
        r_dvs_tvalid <= 1'b0;
        r_dvd_tvalid <= 1'b0;
        r_dvs_acc    <= 1'b0;
        r_dvd_acc    <= 1'b0;
      end else begin
        if (w_dvs_hs) begin
          r_dvs_tvalid <= 1'b0;
          r_dvs_acc    <= 1'b1;
        end
        if (w_dvd_hs) begin
          r_dvd_tvalid <= 1'b0;
          r_dvd_acc    <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/div_issue_ctrl.sv
// Sequences signed/unsigned divider IPs for EXE: issue, wait, present result,
// and drain an in-flight op after a flush so no stale IP output survives.
module div_issue_ctrl
  import div_issue_ctrl_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  div_issue_ctrl_if.master bus,
  output state_t           o_state
);

  state_t        r_state;
  logic [3:0]    r_op;
  logic [DW-1:0] r_src1, r_src2;
  logic [DW-1:0] r_div_result;
  logic          r_div_result_valid;
  logic          r_flush_pend;

  logic          w_div_req, w_start, w_abort_ok, w_sel_signed;
  logic [3:0]    w_new_op;
  logic          w_issued, w_any_acc, w_dout_valid;
  logic          w_s_issued, w_s_any_acc, w_u_issued, w_u_any_acc;
  logic          w_s_dvs_tvalid, w_s_dvd_tvalid, w_u_dvs_tvalid, w_u_dvd_tvalid;
  logic [DW-1:0] w_result;

  assign w_div_req    = bus.ex_valid & (|bus.ex_div_op);
  assign w_new_op     = op_lowest(bus.ex_div_op);
  assign w_start      = (r_state == ST_IDLE) & w_div_req & ~bus.ex_flush;
  assign w_abort_ok   = (r_state == ST_ISSUE) & bus.ex_flush;
  assign w_sel_signed = r_op[OP_DIV_W] | r_op[OP_MOD_W];
  assign w_issued     = w_sel_signed ? w_s_issued : w_u_issued;
  assign w_any_acc    = w_sel_signed ? w_s_any_acc : w_u_any_acc;
  assign w_dout_valid = w_sel_signed ? bus.s_dout_tvalid : bus.u_dout_tvalid;

  div_chan_issue u_s_issue (
    .clk          (clk),
    .rst          (rst),
    .i_start      (w_start & (w_new_op[OP_DIV_W] | w_new_op[OP_MOD_W])),
    .i_abort_ok   (w_abort_ok),
    .i_dvs_tready (bus.s_dvs_tready),
    .i_dvd_tready (bus.s_dvd_tready),
    .o_dvs_tvalid (w_s_dvs_tvalid),
    .o_dvd_tvalid (w_s_dvd_tvalid),
    .o_issued     (w_s_issued),
    .o_any_acc    (w_s_any_acc)
  );

  div_chan_issue u_u_issue (
    .clk          (clk),
    .rst          (rst),
    .i_start      (w_start & (w_new_op[OP_DIV_WU] | w_new_op[OP_MOD_WU])),
    .i_abort_ok   (w_abort_ok),
    .i_dvs_tready (bus.u_dvs_tready),
    .i_dvd_tready (bus.u_dvd_tready),
    .o_dvs_tvalid (w_u_dvs_tvalid),
    .o_dvd_tvalid (w_u_dvd_tvalid),
    .o_issued     (w_u_issued),
    .o_any_acc    (w_u_any_acc)
  );

  // Quotient lives in the upper half of the IP output, remainder in the lower.
  always_comb begin
    w_result = '0;
    if (r_op[OP_DIV_W])       w_result = bus.s_dout_tdata[2*DW-1:DW];
    else if (r_op[OP_MOD_W])  w_result = bus.s_dout_tdata[DW-1:0];
    else if (r_op[OP_DIV_WU]) w_result = bus.u_dout_tdata[2*DW-1:DW];
    else if (r_op[OP_MOD_WU]) w_result = bus.u_dout_tdata[DW-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state            <= ST_IDLE;
      r_op               <= '0;
      r_src1             <= '0;
      r_src2             <= '0;
      r_div_result       <= '0;
      r_div_result_valid <= 1'b0;
      r_flush_pend       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_op         <= w_new_op;
            r_src1       <= bus.ex_src1;
            r_src2       <= bus.ex_src2;
            r_flush_pend <= 1'b0;
            r_state      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          // A half-issued op must complete its other channel before draining.
          if (w_issued) begin
            r_state      <= (bus.ex_flush || r_flush_pend) ? ST_DRAIN : ST_WAIT;
            r_flush_pend <= 1'b0;
          end else if (bus.ex_flush) begin
            if (!w_any_acc) r_state      <= ST_IDLE;
            else            r_flush_pend <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (bus.ex_flush) begin
            r_state <= w_dout_valid ? ST_IDLE : ST_DRAIN;
          end else if (w_dout_valid) begin
            r_div_result       <= w_result;
            r_div_result_valid <= 1'b1;
            r_state            <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (bus.ms_allowin || bus.ex_flush) begin
            r_div_result_valid <= 1'b0;
            r_state            <= ST_IDLE;
          end
        end
        ST_DRAIN: begin
          if (w_dout_valid) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.div_stall        = w_div_req & (r_state != ST_DONE);
  assign bus.div_result       = r_div_result;
  assign bus.div_result_valid = r_div_result_valid;

  assign bus.s_dvs_tvalid = w_s_dvs_tvalid;
  assign bus.s_dvd_tvalid = w_s_dvd_tvalid;
  assign bus.u_dvs_tvalid = w_u_dvs_tvalid;
  assign bus.u_dvd_tvalid = w_u_dvd_tvalid;
  assign bus.s_dvs_tdata  = r_src2;
  assign bus.s_dvd_tdata  = r_src1;
  assign bus.u_dvs_tdata  = r_src2;
  assign bus.u_dvd_tdata  = r_src1;

  assign o_state = r_state;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Directed bench for div_issue_ctrl: the bench plays EXE/MEM and both divider IPs.
module tb_div_issue_ctrl;
  import div_issue_ctrl_pkg::*;

  localparam int DW = 32;

  logic   clk = 1'b0;
  logic   rst;
  state_t dbg_state;

  int n_checks, n_fail;
  int hs_s_dvs, hs_s_dvd, hs_u_dvs, hs_u_dvd;
  int s_tv_seen, u_tv_seen;

  div_issue_ctrl_if #(.DW(DW)) bus_if ();

  div_issue_ctrl #(.DW(DW)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus_if),
    .o_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // handshake monitor
  always @(posedge clk) begin
    if (!rst) begin
      if (bus_if.s_dvs_tvalid && bus_if.s_dvs_tready) hs_s_dvs++;
      if (bus_if.s_dvd_tvalid && bus_if.s_dvd_tready) hs_s_dvd++;
      if (bus_if.u_dvs_tvalid && bus_if.u_dvs_tready) hs_u_dvs++;
      if (bus_if.u_dvd_tvalid && bus_if.u_dvd_tready) hs_u_dvd++;
      if (bus_if.s_dvs_tvalid || bus_if.s_dvd_tvalid) s_tv_seen++;
      if (bus_if.u_dvs_tvalid || bus_if.u_dvd_tvalid) u_tv_seen++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_mon();
    hs_s_dvs = 0; hs_s_dvd = 0; hs_u_dvs = 0; hs_u_dvd = 0;
    s_tv_seen = 0; u_tv_seen = 0;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] tvalids();
    return {bus_if.s_dvs_tvalid, bus_if.s_dvd_tvalid, bus_if.u_dvs_tvalid, bus_if.u_dvd_tvalid};
  endfunction

  task automatic drive_idle();
    bus_if.ex_valid = 1'b0; bus_if.ex_div_op = 4'b0;
    bus_if.ex_src1 = '0; bus_if.ex_src2 = '0;
    bus_if.ex_flush = 1'b0; bus_if.ms_allowin = 1'b0;
    bus_if.s_dvs_tready = 1'b1; bus_if.s_dvd_tready = 1'b1;
    bus_if.u_dvs_tready = 1'b1; bus_if.u_dvd_tready = 1'b1;
    bus_if.s_dout_tvalid = 1'b0; bus_if.s_dout_tdata = '0;
    bus_if.u_dout_tvalid = 1'b0; bus_if.u_dout_tdata = '0;
  endtask

  task automatic drive_op(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    bus_if.ex_valid = 1'b1; bus_if.ex_div_op = op;
    bus_if.ex_src1 = a; bus_if.ex_src2 = b;
  endtask

  task automatic pulse_s(input logic [2*DW-1:0] d);
    bus_if.s_dout_tvalid = 1'b1; bus_if.s_dout_tdata = d;
    tick();
    bus_if.s_dout_tvalid = 1'b0;
  endtask

  task automatic pulse_u(input logic [2*DW-1:0] d);
    bus_if.u_dout_tvalid = 1'b1; bus_if.u_dout_tdata = d;
    tick();
    bus_if.u_dout_tvalid = 1'b0;
  endtask

  task automatic retire();
    bus_if.ms_allowin = 1'b1;
    tick();
    bus_if.ms_allowin = 1'b0;
    bus_if.ex_valid = 1'b0; bus_if.ex_div_op = 4'b0;
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    clear_mon();
    drive_idle();
    rst = 1'b1;
    repeat (3) tick();

    // reset state
    check("rst_state", dbg_state, ST_IDLE);
    check("rst_tvalid", tvalids(), 4'b0000);
    check("rst_result", bus_if.div_result, 0);
    check("rst_valid", bus_if.div_result_valid, 0);
    check("rst_stall", bus_if.div_stall, 0);
    check("rst_dvd_tdata", bus_if.s_dvd_tdata, 0);
    drive_op(4'b0001, 32'd1, 32'd1);
    settle();
    check("rst_stall_req", bus_if.div_stall, 1);
    drive_idle();
    tick();
    rst = 1'b0;
    tick();

    // div_w -7/2, IP latency 10
    drive_op(4'b0001, 32'hFFFF_FFF9, 32'd2);
    settle();
    check("t1_stall_idle", bus_if.div_stall, 1);
    tick();
    check("t1_state_issue", dbg_state, ST_ISSUE);
    check("t1_tvalid", tvalids(), 4'b1100);
    check("t1_dvd_tdata", bus_if.s_dvd_tdata, 32'hFFFF_FFF9);
    check("t1_dvs_tdata", bus_if.s_dvs_tdata, 32'd2);
    tick();
    check("t1_state_wait", dbg_state, ST_WAIT);
    check("t1_tvalid_drop", tvalids(), 4'b0000);
    for (int i = 0; i < 7; i++) begin
      check("t1_stall_wait", bus_if.div_stall, 1);
      tick();
    end
    pulse_u({32'h1, 32'h1});
    check("t1_other_ip_ignored", dbg_state, ST_WAIT);
    bus_if.s_dout_tvalid = 1'b1; bus_if.s_dout_tdata = {32'hFFFF_FFFD, 32'hFFFF_FFFF};
    settle();
    check("t1_valid_before", bus_if.div_result_valid, 0);
    check("t1_stall_at_dout", bus_if.div_stall, 1);
    tick();
    bus_if.s_dout_tvalid = 1'b0;
    check("t1_state_done", dbg_state, ST_DONE);
    check("t1_result", bus_if.div_result, 32'hFFFF_FFFD);
    check("t1_valid", bus_if.div_result_valid, 1);
    check("t1_stall_done", bus_if.div_stall, 0);
    retire();
    settle();
    check("t1_state_idle", dbg_state, ST_IDLE);
    check("t1_valid_clr", bus_if.div_result_valid, 0);
    check("t1_result_hold", bus_if.div_result, 32'hFFFF_FFFD);
    check("t1_hs_dvs", hs_s_dvs, 1);
    check("t1_hs_dvd", hs_s_dvd, 1);

    // non-div op never stalls nor issues
    drive_op(4'b0000, 32'd5, 32'd5);
    settle();
    check("nd_stall", bus_if.div_stall, 0);
    tick();
    check("nd_state", dbg_state, ST_IDLE);
    drive_idle();

    // mod_wu 0xFFFFFFFF % 10, dividend accepted 3 cycles after divisor
    clear_mon();
    bus_if.u_dvd_tready = 1'b0;
    drive_op(4'b1000, 32'hFFFF_FFFF, 32'd10);
    tick();
    check("t2_tvalid", tvalids(), 4'b0011);
    tick();
    check("t2_dvs_taken", tvalids(), 4'b0001);
    tick();
    tick();
    check("t2_still_issue", dbg_state, ST_ISSUE);
    check("t2_dvd_held", tvalids(), 4'b0001);
    bus_if.u_dvd_tready = 1'b1;
    tick();
    check("t2_state_wait", dbg_state, ST_WAIT);
    check("t2_tvalid_drop", tvalids(), 4'b0000);
    tick();
    pulse_u({32'h1999_9999, 32'd5});
    check("t2_result", bus_if.div_result, 32'd5);
    check("t2_valid", bus_if.div_result_valid, 1);
    check("t2_hs_dvs", hs_u_dvs, 1);
    check("t2_hs_dvd", hs_u_dvd, 1);
    check("t2_no_signed", s_tv_seen, 0);
    retire();

    // flush in WAIT (div_wu 100/7), new div op waits behind the drain
    clear_mon();
    drive_op(4'b0100, 32'd100, 32'd7);
    tick();
    tick();
    check("t3_state_wait", dbg_state, ST_WAIT);
    bus_if.ex_flush = 1'b1; bus_if.ex_valid = 1'b0; bus_if.ex_div_op = 4'b0;
    tick();
    bus_if.ex_flush = 1'b0;
    check("t3_state_drain", dbg_state, ST_DRAIN);
    drive_op(4'b0000, 32'd3, 32'd3);
    settle();
    check("t3_nondiv_stall", bus_if.div_stall, 0);
    tick();
    drive_op(4'b0100, 32'd50, 32'd5);
    settle();
    check("t3_div_stall", bus_if.div_stall, 1);
    tick();
    check("t3_still_drain", dbg_state, ST_DRAIN);
    check("t3_no_issue", tvalids(), 4'b0000);
    pulse_u({32'd14, 32'd2});
    check("t3_idle", dbg_state, ST_IDLE);
    check("t3_drain_no_valid", bus_if.div_result_valid, 0);
    check("t3_stall_idle", bus_if.div_stall, 1);
    tick();
    check("t3_issue", tvalids(), 4'b0011);
    check("t3_dvd_tdata", bus_if.u_dvd_tdata, 32'd50);
    tick();
    pulse_u({32'd10, 32'd0});
    check("t3_result", bus_if.div_result, 32'd10);
    check("t3_valid", bus_if.div_result_valid, 1);
    check("t3_hs_dvs", hs_u_dvs, 2);
    retire();

    // flush in ISSUE after divisor accepted only
    clear_mon();
    bus_if.s_dvd_tready = 1'b0;
    drive_op(4'b0001, 32'd9, 32'd4);
    tick();
    tick();
    check("t4_half", tvalids(), 4'b0100);
    bus_if.ex_flush = 1'b1; bus_if.ex_valid = 1'b0; bus_if.ex_div_op = 4'b0;
    tick();
    bus_if.ex_flush = 1'b0;
    check("t4_state_issue", dbg_state, ST_ISSUE);
    check("t4_dvd_held", tvalids(), 4'b0100);
    tick();
    bus_if.s_dvd_tready = 1'b1;
    tick();
    check("t4_state_drain", dbg_state, ST_DRAIN);
    check("t4_tvalid_drop", tvalids(), 4'b0000);
    check("t4_hs_dvs", hs_s_dvs, 1);
    check("t4_hs_dvd", hs_s_dvd, 1);
    tick();
    pulse_s({32'd2, 32'd1});
    check("t4_state_idle", dbg_state, ST_IDLE);
    check("t4_no_valid", bus_if.div_result_valid, 0);
    check("t4_result_hold", bus_if.div_result, 32'd10);

    // flush in ISSUE before any channel accepted
    bus_if.s_dvs_tready = 1'b0; bus_if.s_dvd_tready = 1'b0;
    drive_op(4'b0010, 32'd9, 32'd4);
    tick();
    check("t4b_tvalid", tvalids(), 4'b1100);
    bus_if.ex_flush = 1'b1; bus_if.ex_valid = 1'b0; bus_if.ex_div_op = 4'b0;
    tick();
    bus_if.ex_flush = 1'b0;
    bus_if.s_dvs_tready = 1'b1; bus_if.s_dvd_tready = 1'b1;
    check("t4b_state_idle", dbg_state, ST_IDLE);
    check("t4b_tvalid_drop", tvalids(), 4'b0000);
    tick();
    check("t4b_stays_idle", tvalids(), 4'b0000);

    // back-to-back div_w 20/3 then mod_w 20/3
    clear_mon();
    drive_op(4'b0001, 32'd20, 32'd3);
    tick();
    tick();
    pulse_s({32'd6, 32'd2});
    check("t5_result_div", bus_if.div_result, 32'd6);
    bus_if.ms_allowin = 1'b1;
    tick();
    bus_if.ms_allowin = 1'b0;
    bus_if.ex_div_op = 4'b0010;
    settle();
    check("t5_idle", dbg_state, ST_IDLE);
    check("t5_valid_clr", bus_if.div_result_valid, 0);
    check("t5_stall", bus_if.div_stall, 1);
    tick();
    tick();
    pulse_s({32'd6, 32'd2});
    check("t5_result_mod", bus_if.div_result, 32'd2);
    check("t5_valid", bus_if.div_result_valid, 1);
    retire();
    check("t5_hs_dvs", hs_s_dvs, 2);
    check("t5_hs_dvd", hs_s_dvd, 2);
    check("t5_end_idle", dbg_state, ST_IDLE);

    // reset while waiting for the IP
    drive_op(4'b0001, 32'd5, 32'd1);
    tick();
    tick();
    check("t6_state_wait", dbg_state, ST_WAIT);
    rst = 1'b1; bus_if.ex_valid = 1'b0; bus_if.ex_div_op = 4'b0;
    tick();
    rst = 1'b0;
    check("t6_state_idle", dbg_state, ST_IDLE);
    check("t6_tvalid", tvalids(), 4'b0000);
    check("t6_result", bus_if.div_result, 0);
    check("t6_dvs_tdata", bus_if.s_dvs_tdata, 0);
    pulse_s({32'd5, 32'd0});
    check("t6_late_dout_state", dbg_state, ST_IDLE);
    check("t6_late_dout_valid", bus_if.div_result_valid, 0);
    check("t6_late_dout_result", bus_if.div_result, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
